upsampling_core_2x2_cxy: RTL and testbench
==========================================

Name: upsampling_core_2x2_cxy

Overview:
Nearest-neighbour 2x2 unpooling core, the inverse of the 2x2 max-pooling stage in the CNN pipeline. Accepts a (P_WIDTH/2)x(P_HEIGHT/2) raster stream with line/frame markers and emits a P_WIDTH x P_HEIGHT raster stream. Each input pixel is duplicated horizontally, and each input line is replayed once from an internal line buffer. It sits on the decoder/upsampling side of the feature-map datapath, with downstream back-pressure.

Parameters:
P_WIDTH, 64, output frame width in pixels (even, >=4)
P_HEIGHT, 64, output frame height in lines (even, >=2)
P_WCNT_W, 6, log2(P_WIDTH); input column counter is P_WCNT_W-1 bits
P_HCNT_W, 6, log2(P_HEIGHT); input line counter is P_HCNT_W-1 bits
DW, 24, pixel data width

Ports:
CLK  in  1  clock, all logic on rising edge
RSTn  in  1  reset; one clock; reset is asynchronous and active-low
DIN_VALID  in  1  input pixel present
DIN  in  DW  input pixel
DIN_LAST_IN_LINE  in  1  qualifies DIN: last pixel of input line
DIN_LAST_PIX  in  1  qualifies DIN: last pixel of input frame
DIN_READY  out  1  input accepted this cycle when DIN_VALID & DIN_READY
OUT  out  DW  output pixel (registered)
VALID  out  1  OUT valid
LAST_IN_LINE  out  1  qualifies OUT: last pixel of output line
LAST_PIX  out  1  qualifies OUT: last pixel of output frame
OUT_READY  in  1  downstream accepts OUT when VALID & OUT_READY
FRAME_ERR  out  1  sticky input framing error flag

Behaviour:
- Reset (async, RSTn=0): state<=S_ROW_A, ph<=0, h_cnt<=0, v_cnt<=0, OUT<=0, VALID/LAST_IN_LINE/LAST_PIX/FRAME_ERR<=0. Line buffer contents are not reset. Reset mid-frame discards the partial frame; the next accepted pixel is treated as frame pixel (0,0).
- load = ~VALID | OUT_READY. The output register updates only when load=1. If load=1 and nothing is emitted, VALID<=0. While VALID & ~OUT_READY, OUT/VALID/LAST_* are held stable.
- DIN_READY = (state==S_ROW_A) & (ph==0) & load. Combinational; never depends on DIN_VALID.
- Line buffer: P_WIDTH/2 x DW register array. Written at h_cnt on input accept. Read combinationally at h_cnt in S_ROW_B.
- S_ROW_A (live input line):
  - ph=0, accept: buf[h_cnt]<=DIN; hold<=DIN; OUT<=DIN; VALID<=1; LAST_*<=0; ph<=1.
  - ph=1, load: OUT<=hold (second copy); VALID<=1; ph<=0.
    - If h_cnt==P_WIDTH/2-1: LAST_IN_LINE<=1, h_cnt<=0, ->S_ROW_B.
    - Else h_cnt<=h_cnt+1.
- S_ROW_B (replay): each load emits buf[h_cnt]; ph toggles; h_cnt increments after the second copy.
  - Last copy of the row: LAST_IN_LINE<=1; h_cnt<=0; ->S_ROW_A.
    - If v_cnt==P_HEIGHT/2-1: LAST_PIX<=1, v_cnt<=0.
    - Else v_cnt<=v_cnt+1.
  - DIN_READY=0 throughout.
- Latency: accepted pixel appears on OUT the next cycle. Second copy follows one cycle later if OUT_READY=1. Steady state is one output per cycle; input sustains at most one pixel per 2 cycles during row A and zero during row B.
- Framing check on accept:
  - Error if DIN_LAST_IN_LINE != (h_cnt==P_WIDTH/2-1).
  - Error if DIN_LAST_PIX != (h_cnt==P_WIDTH/2-1 & v_cnt==P_HEIGHT/2-1).
  - On error, FRAME_ERR<=1 (sticky until reset). Internal counters stay authoritative; output framing is never resynchronised to the input markers.
- Back-to-back frames: no idle cycles required between LAST_PIX and the next frame's first pixel.
- Data is passed unmodified, no arithmetic; all-ones values are preserved.

Test Plan:
- P_WIDTH=4, P_HEIGHT=4, OUT_READY=1, input 1,2,3,4 with correct markers -> OUT 1,1,2,2,1,1,2,2,3,3,4,4,3,3,4,4. LAST_IN_LINE on outputs 3,7,11,15; LAST_PIX only on output 15. FRAME_ERR=0.
- Same stimulus with OUT_READY toggling 1,0,0,1,... -> identical output sequence. OUT/VALID/LAST_* hold while stalled. DIN_READY=0 on every cycle where load=0.
- DIN_VALID held high throughout -> DIN_READY pattern 1,0 during row A and 0 for the 4 cycles of row B. Exactly 4 inputs consumed per frame.
- DIN_LAST_IN_LINE asserted on input pixel 0 -> FRAME_ERR=1 from the next cycle. Output still 16 pixels with markers at 3,7,11,15. FRAME_ERR stays 1 across the following frame.
- RSTn pulsed low mid-row-B (asynchronously, between edges) -> VALID=0 immediately. A new frame 9,8,7,6 yields 9,9,8,8,9,9,8,8,7,7,6,6,7,7,6,6.
- Two frames back-to-back, DIN=24'hFFFFFF then 24'h000001 -> values preserved. The second frame starts on the cycle after LAST_PIX with no gap.

Source files
------------

// File: rtl/upsampling_core_2x2_cxy.sv
// upsampling_core_2x2_cxy: nearest-neighbour 2x2 unpooling; each input pixel is doubled
// horizontally and each input line is replayed once from a line buffer.
module upsampling_core_2x2_cxy #(
   parameter int P_WIDTH  = 64,
   parameter int P_HEIGHT = 64,
   parameter int P_WCNT_W = 6,
   parameter int P_HCNT_W = 6,
   parameter int DW       = 24
) (
   input  logic          CLK,
   input  logic          RSTn,
   input  logic          DIN_VALID,
   input  logic [DW-1:0] DIN,
   input  logic          DIN_LAST_IN_LINE,
   input  logic          DIN_LAST_PIX,
   output logic          DIN_READY,
   output logic [DW-1:0] OUT,
   output logic          VALID,
   output logic          LAST_IN_LINE,
   output logic          LAST_PIX,
   input  logic          OUT_READY,
   output logic          FRAME_ERR
);
   localparam int HW = P_WIDTH / 2;
   localparam int HH = P_HEIGHT / 2;

   typedef enum logic {S_ROW_A, S_ROW_B} state_t;

   state_t              state;
   logic                ph;
   logic [P_WCNT_W-2:0] h_cnt;
   logic [P_HCNT_W-2:0] v_cnt;
   logic [DW-1:0]       hold;
   logic [DW-1:0]       line_buf [HW];
   logic                load, accept, h_last, v_last;

   assign load      = ~VALID | OUT_READY;
   assign DIN_READY = (state == S_ROW_A) & ~ph & load;
   assign accept    = DIN_VALID & DIN_READY;
   assign h_last    = h_cnt == (P_WCNT_W-1)'(HW - 1);
   assign v_last    = v_cnt == (P_HCNT_W-1)'(HH - 1);

   // Line storage is deliberately left out of reset; it is always rewritten before replay.
   always_ff @(posedge CLK) begin
      if (accept) begin
         line_buf[h_cnt] <= DIN;
         hold            <= DIN;
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state        <= S_ROW_A;
         ph           <= 1'b0;
         h_cnt        <= '0;
         v_cnt        <= '0;
         OUT          <= '0;
         VALID        <= 1'b0;
         LAST_IN_LINE <= 1'b0;
         LAST_PIX     <= 1'b0;
         FRAME_ERR    <= 1'b0;
      end else begin
         if (accept && (DIN_LAST_IN_LINE != h_last || DIN_LAST_PIX != (h_last & v_last)))
            FRAME_ERR <= 1'b1;
         if (load) begin
            if (state == S_ROW_A && !ph) begin
               VALID <= accept;
               if (accept) begin
                  OUT          <= DIN;
                  LAST_IN_LINE <= 1'b0;
                  LAST_PIX     <= 1'b0;
                  ph           <= 1'b1;
               end
            end else begin
               OUT          <= (state == S_ROW_A) ? hold : line_buf[h_cnt];
               VALID        <= 1'b1;
               ph           <= ~ph;
               LAST_IN_LINE <= 1'b0;
               LAST_PIX     <= 1'b0;
               // Second copy of a pixel: advance the column, and close the row on its last column.
               if (ph) begin
                  LAST_IN_LINE <= h_last;
                  h_cnt        <= h_last ? '0 : h_cnt + 1'b1;
                  if (h_last)
                     state <= (state == S_ROW_A) ? S_ROW_B : S_ROW_A;
                  if (h_last && state == S_ROW_B) begin
                     LAST_PIX <= v_last;
                     v_cnt    <= v_last ? '0 : v_cnt + 1'b1;
                  end
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_upsampling_core_2x2_cxy.sv
// tb_upsampling_core_2x2_cxy: randomized self-checking bench for the 2x2 unpooling core
// against a frame-level reference model.
module tb_upsampling_core_2x2_cxy;
   localparam int W    = 4;
   localparam int H    = 4;
   localparam int DW   = 24;
   localparam int NIN  = (W / 2) * (H / 2);
   localparam int NOUT = W * H;

   logic          CLK = 1'b0, RSTn = 1'b0;
   logic          DIN_VALID = 1'b0, DIN_LAST_IN_LINE = 1'b0, DIN_LAST_PIX = 1'b0, OUT_READY = 1'b0;
   logic [DW-1:0] DIN = '0;
   logic          DIN_READY, VALID, LAST_IN_LINE, LAST_PIX, FRAME_ERR;
   logic [DW-1:0] OUT;

   int checks = 0, errors = 0;
   logic [DW-1:0] din_arr[$], exp_d[$], obs_d[$];
   bit            exp_l[$], exp_p[$], obs_l[$], obs_p[$], rdy_tr[$];
   int            obs_cyc[$];
   int            acc_cnt, hold_viol, ready_viol;
   bit            ferr_next;

   upsampling_core_2x2_cxy #(.P_WIDTH(W), .P_HEIGHT(H), .P_WCNT_W(2), .P_HCNT_W(2), .DW(DW)) dut (
      .CLK(CLK), .RSTn(RSTn), .DIN_VALID(DIN_VALID), .DIN(DIN),
      .DIN_LAST_IN_LINE(DIN_LAST_IN_LINE), .DIN_LAST_PIX(DIN_LAST_PIX), .DIN_READY(DIN_READY),
      .OUT(OUT), .VALID(VALID), .LAST_IN_LINE(LAST_IN_LINE), .LAST_PIX(LAST_PIX),
      .OUT_READY(OUT_READY), .FRAME_ERR(FRAME_ERR)
   );

   always #5 CLK = ~CLK;

   // Reference: every input row becomes two output rows, every pixel two output columns.
   task automatic build_expected(input int nfr);
      exp_d.delete(); exp_l.delete(); exp_p.delete();
      for (int f = 0; f < nfr; f++)
         for (int r = 0; r < H / 2; r++)
            for (int rep = 0; rep < 2; rep++)
               for (int c = 0; c < W / 2; c++)
                  for (int k = 0; k < 2; k++) begin
                     exp_l.push_back(exp_d.size() % W == W - 1);
                     exp_p.push_back(exp_d.size() % NOUT == NOUT - 1);
                     exp_d.push_back(din_arr[f * NIN + r * (W / 2) + c]);
                  end
   endtask

   task automatic fill_random(input int nfr);
      din_arr.delete();
      for (int i = 0; i < nfr * NIN; i++) din_arr.push_back(DW'($urandom));
   endtask

   // rmode: 0 ready always, 1 pattern 1,0,0, 2 random; vmode: 0 valid always, 1 random.
   task automatic run_stream(input int nout, input int rmode, input int vmode, input int eidx);
      int idx = 0, cyc = 0;
      bit pv = 0, pr = 1, pl = 0, pp = 0, chk_err = 0;
      logic [DW-1:0] pd = '0;
      obs_d.delete(); obs_l.delete(); obs_p.delete(); obs_cyc.delete(); rdy_tr.delete();
      acc_cnt = 0; hold_viol = 0; ready_viol = 0; ferr_next = 0;
      while (obs_d.size() < nout) begin
         @(posedge CLK); #1;
         OUT_READY        = rmode == 0 ? 1'b1 : rmode == 1 ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
         DIN_VALID        = vmode == 0 ? 1'b1 : ($urandom_range(0, 3) != 0);
         DIN              = idx < din_arr.size() ? din_arr[idx] : DW'($urandom);
         DIN_LAST_IN_LINE = (idx % (W / 2) == W / 2 - 1) ^ (idx == eidx);
         DIN_LAST_PIX     = idx % NIN == NIN - 1;
         @(negedge CLK);
         if (chk_err) begin ferr_next = FRAME_ERR; chk_err = 0; end
         if (pv && !pr && (VALID !== pv || OUT !== pd || LAST_IN_LINE !== pl || LAST_PIX !== pp)) hold_viol++;
         if (VALID && !OUT_READY && DIN_READY) ready_viol++;
         rdy_tr.push_back(DIN_READY);
         if (VALID && OUT_READY) begin
            obs_d.push_back(OUT); obs_l.push_back(LAST_IN_LINE); obs_p.push_back(LAST_PIX); obs_cyc.push_back(cyc);
         end
         if (obs_d.size() >= nout) break;
         if (DIN_VALID && DIN_READY) begin
            if (idx == eidx) chk_err = 1;
            idx++; acc_cnt++;
         end
         pv = VALID; pr = OUT_READY; pd = OUT; pl = LAST_IN_LINE; pp = LAST_PIX;
         cyc++;
         if (cyc > 3000) begin
            checks++; errors++;
            $display("FAIL timeout: got %0d outputs, want %0d", obs_d.size(), nout);
            break;
         end
      end
      DIN_VALID = 1'b0;
   endtask

   task automatic test_reset;
      #12;
      checks += 6;
      if (VALID !== 1'b0)        begin errors++; $display("FAIL reset VALID: got %b want 0", VALID); end
      if (OUT !== '0)            begin errors++; $display("FAIL reset OUT: got %h want 0", OUT); end
      if (LAST_IN_LINE !== 1'b0) begin errors++; $display("FAIL reset LAST_IN_LINE: got %b want 0", LAST_IN_LINE); end
      if (LAST_PIX !== 1'b0)     begin errors++; $display("FAIL reset LAST_PIX: got %b want 0", LAST_PIX); end
      if (FRAME_ERR !== 1'b0)    begin errors++; $display("FAIL reset FRAME_ERR: got %b want 0", FRAME_ERR); end
      if (DIN_READY !== 1'b1)    begin errors++; $display("FAIL reset DIN_READY: got %b want 1", DIN_READY); end
      @(negedge CLK); RSTn = 1'b1;
   endtask

   task automatic test_basic;
      din_arr = '{24'd1, 24'd2, 24'd3, 24'd4};
      build_expected(1);
      run_stream(NOUT, 0, 0, -1);
      for (int i = 0; i < NOUT; i++) begin
         checks++;
         if (i >= obs_d.size() || obs_d[i] !== exp_d[i] || obs_l[i] !== exp_l[i] || obs_p[i] !== exp_p[i]) begin
            errors++;
            $display("FAIL basic out[%0d]: got %h/%b/%b want %h/%b/%b", i, obs_d[i], obs_l[i], obs_p[i], exp_d[i], exp_l[i], exp_p[i]);
         end
      end
      checks++;
      if (FRAME_ERR !== 1'b0) begin errors++; $display("FAIL basic FRAME_ERR: got %b want 0", FRAME_ERR); end
   endtask

   task automatic test_stall;
      din_arr = '{24'd1, 24'd2, 24'd3, 24'd4};
      build_expected(1);
      run_stream(NOUT, 1, 0, -1);
      for (int i = 0; i < NOUT; i++) begin
         checks++;
         if (i >= obs_d.size() || obs_d[i] !== exp_d[i] || obs_l[i] !== exp_l[i] || obs_p[i] !== exp_p[i]) begin
            errors++;
            $display("FAIL stall out[%0d]: got %h/%b/%b want %h/%b/%b", i, obs_d[i], obs_l[i], obs_p[i], exp_d[i], exp_l[i], exp_p[i]);
         end
      end
      checks += 2;
      if (hold_viol != 0)  begin errors++; $display("FAIL stall hold: got %0d changes while stalled, want 0", hold_viol); end
      if (ready_viol != 0) begin errors++; $display("FAIL stall din_ready: got %0d ready cycles with load=0, want 0", ready_viol); end
   endtask

   task automatic test_ready_pattern;
      fill_random(2);
      build_expected(2);
      run_stream(2 * NOUT, 0, 0, -1);
      for (int k = 0; k < rdy_tr.size(); k++) begin
         checks++;
         if (rdy_tr[k] !== (k % 8 == 0 || k % 8 == 2)) begin
            errors++;
            $display("FAIL ready_pattern cycle %0d: got %b want %b", k, rdy_tr[k], (k % 8 == 0 || k % 8 == 2));
         end
      end
      checks++;
      if (acc_cnt != 2 * NIN) begin errors++; $display("FAIL ready_pattern accepts: got %0d want %0d", acc_cnt, 2 * NIN); end
   endtask

   task automatic test_random;
      fill_random(3);
      build_expected(3);
      run_stream(3 * NOUT, 2, 1, -1);
      for (int i = 0; i < 3 * NOUT; i++) begin
         checks++;
         if (i >= obs_d.size() || obs_d[i] !== exp_d[i] || obs_l[i] !== exp_l[i] || obs_p[i] !== exp_p[i]) begin
            errors++;
            $display("FAIL random out[%0d]: got %h/%b/%b want %h/%b/%b", i, obs_d[i], obs_l[i], obs_p[i], exp_d[i], exp_l[i], exp_p[i]);
         end
      end
      checks += 3;
      if (hold_viol != 0)     begin errors++; $display("FAIL random hold: got %0d want 0", hold_viol); end
      if (ready_viol != 0)    begin errors++; $display("FAIL random din_ready: got %0d want 0", ready_viol); end
      if (FRAME_ERR !== 1'b0) begin errors++; $display("FAIL random FRAME_ERR: got %b want 0", FRAME_ERR); end
   endtask

   task automatic test_frame_err;
      fill_random(2);
      build_expected(2);
      run_stream(2 * NOUT, 0, 1, 0);
      for (int i = 0; i < 2 * NOUT; i++) begin
         checks++;
         if (i >= obs_d.size() || obs_d[i] !== exp_d[i] || obs_l[i] !== exp_l[i] || obs_p[i] !== exp_p[i]) begin
            errors++;
            $display("FAIL frame_err out[%0d]: got %h/%b/%b want %h/%b/%b", i, obs_d[i], obs_l[i], obs_p[i], exp_d[i], exp_l[i], exp_p[i]);
         end
      end
      checks += 2;
      if (ferr_next !== 1'b1) begin errors++; $display("FAIL frame_err next cycle: got %b want 1", ferr_next); end
      if (FRAME_ERR !== 1'b1) begin errors++; $display("FAIL frame_err sticky: got %b want 1", FRAME_ERR); end
   endtask

   task automatic test_async_reset;
      din_arr = '{24'd1, 24'd2, 24'd3, 24'd4};
      run_stream(5, 0, 0, -1);
      #2 RSTn = 1'b0;
      #1;
      checks += 3;
      if (VALID !== 1'b0)     begin errors++; $display("FAIL async_reset VALID: got %b want 0", VALID); end
      if (OUT !== '0)         begin errors++; $display("FAIL async_reset OUT: got %h want 0", OUT); end
      if (FRAME_ERR !== 1'b0) begin errors++; $display("FAIL async_reset FRAME_ERR: got %b want 0", FRAME_ERR); end
      #1 RSTn = 1'b1;
      din_arr = '{24'd9, 24'd8, 24'd7, 24'd6};
      build_expected(1);
      run_stream(NOUT, 0, 0, -1);
      for (int i = 0; i < NOUT; i++) begin
         checks++;
         if (i >= obs_d.size() || obs_d[i] !== exp_d[i] || obs_l[i] !== exp_l[i] || obs_p[i] !== exp_p[i]) begin
            errors++;
            $display("FAIL async_reset out[%0d]: got %h/%b/%b want %h/%b/%b", i, obs_d[i], obs_l[i], obs_p[i], exp_d[i], exp_l[i], exp_p[i]);
         end
      end
   endtask

   task automatic test_back_to_back;
      din_arr = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'h000001, 24'h000001, 24'h000001, 24'h000001};
      build_expected(2);
      run_stream(2 * NOUT, 0, 0, -1);
      for (int i = 0; i < 2 * NOUT; i++) begin
         checks++;
         if (i >= obs_d.size() || obs_d[i] !== exp_d[i] || obs_l[i] !== exp_l[i] || obs_p[i] !== exp_p[i]) begin
            errors++;
            $display("FAIL back_to_back out[%0d]: got %h/%b/%b want %h/%b/%b", i, obs_d[i], obs_l[i], obs_p[i], exp_d[i], exp_l[i], exp_p[i]);
         end
      end
      checks++;
      if (obs_cyc.size() < NOUT + 1 || obs_cyc[NOUT] - obs_cyc[NOUT-1] != 1) begin
         errors++;
         $display("FAIL back_to_back gap: got %0d cycles between frames, want 1",
                  obs_cyc.size() > NOUT ? obs_cyc[NOUT] - obs_cyc[NOUT-1] : -1);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_ready_pattern();
      test_random();
      test_frame_err();
      test_async_reset();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
